// File: rtl/mini_alu_pkg.sv
// Shared Mini ALU definitions: FSM encodings, digit width, counter sizing.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package mini_alu_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width for a WIDTH-bit operand: clog2(WIDTH/2), at least 1.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / DIGIT_W);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_mag_compare_if.sv
// Operand handshake and verdict bundle for serial_mag_compare.
// Latency: n/a (wires only).
// Backpressure: in_ready gates acceptance; master must hold in_valid until in_ready.
// Ports: in_valid/a/b from master; in_ready/busy/done/a_gt_b/a_eq_b/a_lt_b from slave.
interface serial_mag_compare_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    modport master (
        output in_valid, a, b,
        input  in_ready, busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  in_valid, a, b,
        output in_ready, busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface

// File: rtl/digit_cmp2.sv
// Combinational unsigned compare of one 2-bit digit pair.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: x, y digits in; gt (x > y), eq (x == y) out.
module digit_cmp2
    import mini_alu_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic               gt,
    output logic               eq
);
    assign gt = (x > y);
    assign eq = (x == y);
endmodule

// File: rtl/serial_mag_compare.sv
// Serial unsigned magnitude comparator: one 2-bit digit per clock, MSB digit first.
// Latency: WIDTH/2 cycles in RUN after the accept edge, then one DONE cycle.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, not queued.
// Ports: clk, reset_n (async active-low); bus = slave side of serial_mag_compare_if.
module serial_mag_compare
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_mag_compare_if.slave  bus
);
    localparam int D  = WIDTH / DIGIT_W;
    localparam int CW = cnt_width(WIDTH);

    if ((WIDTH < DIGIT_W) || ((WIDTH % DIGIT_W) != 0)) begin : g_width_chk
        $error("serial_mag_compare: WIDTH must be even and >= 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [CW-1:0]    cnt_q;
    logic             decided_q, gt_q, lt_q;
    logic             res_gt_q, res_eq_q, res_lt_q;

    logic dig_gt, dig_eq, dig_lt;
    logic gt_nxt, lt_nxt;

    digit_cmp2 u_digit_cmp2 (
        .x  (sa_q[WIDTH-1 -: DIGIT_W]),
        .y  (sb_q[WIDTH-1 -: DIGIT_W]),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    assign dig_lt = ~dig_gt & ~dig_eq;

    // First differing digit wins; once decided, lower digits cannot change it.
    assign gt_nxt = gt_q | (~decided_q & dig_gt);
    assign lt_nxt = lt_q | (~decided_q & dig_lt);

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            res_gt_q  <= 1'b0;
            res_eq_q  <= 1'b0;
            res_lt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sa_q      <= bus.a;
                        sb_q      <= bus.b;
                        cnt_q     <= CW'(D - 1);
                        decided_q <= 1'b0;
                        gt_q      <= 1'b0;
                        lt_q      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sa_q      <= sa_q << DIGIT_W;
                    sb_q      <= sb_q << DIGIT_W;
                    decided_q <= decided_q | ~dig_eq;
                    gt_q      <= gt_nxt;
                    lt_q      <= lt_nxt;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Last digit: the verdict includes this edge's digit.
                        res_gt_q <= gt_nxt;
                        res_lt_q <= lt_nxt;
                        res_eq_q <= ~gt_nxt & ~lt_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.a_gt_b = res_gt_q;
    assign bus.a_eq_b = res_eq_q;
    assign bus.a_lt_b = res_lt_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Bench for serial_mag_compare: WIDTH=8 and WIDTH=2 instances on one clock/reset.
module tb_serial_mag_compare;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    serial_mag_compare_if #(.WIDTH(8)) bus8 ();
    serial_mag_compare_if #(.WIDTH(2)) bus2 ();

    serial_mag_compare #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    serial_mag_compare #(.WIDTH(2)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands at a negedge; the following posedge is the handshake edge E0.
    // Returns at the negedge just after E0.
    task automatic start8(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.a        = av;
        bus8.b        = bv;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a        = 8'hxx;
        bus8.b        = 8'hxx;
    endtask

    // Counts edges after E0 until done is seen (bounded).
    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.a        = '0;
        bus8.b        = '0;
        bus2.in_valid = 1'b0;
        bus2.a        = '0;
        bus2.b        = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus8.in_ready, bus8.busy, bus8.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/busy/done=%b want 100", {bus8.in_ready, bus8.busy, bus8.done});
        end
        checks++;
        if ({bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b} !== 3'b000) begin
            errors++;
            $display("FAIL reset_res got %b want 000", {bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One compare on the WIDTH=8 block with hand-worked verdict {gt,eq,lt}.
    task automatic test_compare(input string nm, input logic [7:0] av, input logic [7:0] bv,
                                input logic [2:0] exp_res);
        int cyc;
        start8(av, bv);
        wait_done8(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL %s_latency got %0d edges want 4", nm, cyc);
        end
        checks++;
        if ({bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b} !== exp_res || bus8.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_result got gt/eq/lt=%b busy=%b want %b busy=1", nm,
                     {bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b}, bus8.busy, exp_res);
        end
        @(negedge clk);
        checks++;
        if ({bus8.done, bus8.in_ready, bus8.busy} !== 3'b010) begin
            errors++;
            $display("FAIL %s_after got done/rdy/busy=%b want 010", nm, {bus8.done, bus8.in_ready, bus8.busy});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b} !== exp_res) begin
            errors++;
            $display("FAIL %s_hold got %b want %b", nm, {bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b}, exp_res);
        end
    endtask

    // in_valid held high, operands changing every cycle: accepts at k=0,6,12,
    // done visible at k=5,11,17 carrying the verdict of operands at k-5.
    task automatic test_back_to_back();
        logic [7:0] va [18];
        logic [7:0] vb [18];
        logic [2:0] exp_res;
        for (int k = 0; k < 18; k++) begin
            va[k] = 8'((k * 37) + 11);
            vb[k] = 8'((k * 53) + 7);
        end
        vb[12] = va[12];
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            checks++;
            if (bus8.in_ready !== ((k % 6) == 0) || bus8.done !== ((k % 6) == 5)) begin
                errors++;
                $display("FAIL b2b_timing k=%0d got rdy=%b done=%b want rdy=%b done=%b", k,
                         bus8.in_ready, bus8.done, ((k % 6) == 0), ((k % 6) == 5));
            end
            checks++;
            if (bus8.in_ready === 1'b1 && bus8.busy === 1'b1) begin
                errors++;
                $display("FAIL b2b_rdy_busy k=%0d got rdy=1 busy=1 want not both", k);
            end
            if ((k % 6) == 5) begin
                exp_res = {va[k-5] > vb[k-5], va[k-5] == vb[k-5], va[k-5] < vb[k-5]};
                checks++;
                if ({bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b} !== exp_res) begin
                    errors++;
                    $display("FAIL b2b_result k=%0d got %b want %b", k,
                             {bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b}, exp_res);
                end
            end
            bus8.in_valid = 1'b1;
            bus8.a        = va[k];
            bus8.b        = vb[k];
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int seen_done;
        start8(8'hB4, 8'h40);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus8.in_ready, bus8.busy, bus8.done, bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b} !== 6'b100000) begin
            errors++;
            $display("FAIL midrst_async got rdy/busy/done/res=%b want 100000",
                     {bus8.in_ready, bus8.busy, bus8.done, bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b});
        end
        @(negedge clk);
        reset_n   = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_nodone got dones=%0d rdy=%b want 0 and 1", seen_done, bus8.in_ready);
        end
        start8(8'h12, 8'h13);
        wait_done8(cyc);
        checks++;
        if (cyc !== 4 || {bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_next got edges=%0d res=%b want 4 and 001", cyc,
                     {bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b});
        end
        @(negedge clk);
    endtask

    task automatic test_width2_sweep();
        int         cyc;
        logic [2:0] exp_res;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                bus2.in_valid = 1'b1;
                bus2.a        = 2'(i);
                bus2.b        = 2'(j);
                @(negedge clk);
                bus2.in_valid = 1'b0;
                cyc = 0;
                while (bus2.done !== 1'b1 && cyc < 10) begin
                    @(negedge clk);
                    cyc++;
                end
                exp_res = {i > j, i == j, i < j};
                checks++;
                if (cyc !== 1 || {bus2.a_gt_b, bus2.a_eq_b, bus2.a_lt_b} !== exp_res) begin
                    errors++;
                    $display("FAIL w2_%0d_%0d got edges=%0d res=%b want 1 and %b", i, j, cyc,
                             {bus2.a_gt_b, bus2.a_eq_b, bus2.a_lt_b}, exp_res);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        // B4=10_11_01_00, B3=10_11_00_11: third digit 01>00.
        test_compare("gt_low_digit", 8'hB4, 8'hB3, 3'b100);
        test_compare("eq", 8'h5A, 8'h5A, 3'b010);
        // 40=01_.., FF=11_..: decided on the first digit, still 4 edges.
        test_compare("lt_msb", 8'h40, 8'hFF, 3'b001);
        test_compare("gt_msb", 8'hFF, 8'h40, 3'b100);
        test_back_to_back();
        test_reset_mid_run();
        test_width2_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_mag_compare.md
# serial_mag_compare

Sequential N-bit magnitude comparator for the Mini ALU. It accepts two WIDTH-bit operands over a valid/ready handshake and slices them into 2-bit digit pairs, MSB digit first. Each pair is fed through a 2-bit digit compare slice, one digit per clock, and the block accumulates a single registered greater/equal/less verdict. It sits upstream of the ALU result mux, so the 2-bit compare hardware can serve operands of any even width.

## Interface

- WIDTH, 8: operand width in bits. Must be even and at least 2; any other value is an elaboration error.
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b present this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- busy  output  1  comparison in progress (RUN or DONE).
- done  output  1  one-cycle pulse: results valid/updated this cycle.
- a_gt_b  output  1  registered result, A > B.
- a_eq_b  output  1  registered result, A == B.
- a_lt_b  output  1  registered result, A < B.

## Operation

- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- The FSM has three states.
  - IDLE: in_ready=1, busy=0.
  - RUN: in_ready=0, busy=1.
  - DONE: in_ready=0, busy=1, done=1.
- IDLE -> RUN on the edge where in_valid && in_ready (the handshake). On that edge:
  - a and b load into internal shift registers sa and sb.
  - The digit counter loads D-1, where D = WIDTH/2.
  - The decided, gt and lt flags clear.
- Each RUN edge compares the digit pair sa[WIDTH-1:WIDTH-2] and sb[WIDTH-1:WIDTH-2]:
  - If not yet decided and the digit of A is greater: gt=1, decided=1.
  - If not yet decided and the digit of A is less: lt=1, decided=1.
  - Once decided, later digits are ignored.
  - sa and sb then shift left by 2 and the counter decrements.
- RUN -> DONE on the edge where the counter is 0 (the last digit is processed on that edge). On this edge the result registers load:
  - a_gt_b = gt
  - a_lt_b = lt
  - a_eq_b = ~gt & ~lt
- DONE -> IDLE unconditionally on the next edge.
- Latency is fixed at D cycles in RUN regardless of where the digits first differ; there is no early exit.
- Exactly one of a_gt_b, a_eq_b, a_lt_b is high after any completed comparison.
- Results hold their value until the next DONE.
- Arithmetic: operands are unsigned. The digit slice compares two 2-bit values and produces digit_gt and digit_eq; digit_lt = ~digit_gt & ~digit_eq.

## Timing

- Reset values: state=IDLE, in_ready=1, busy=0, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0, counter=0, sa=sb=0.
- Let E0 be the handshake edge. The FSM is in RUN for edges E1..ED, and DONE is entered at edge ED. done is high in the cycle between ED and ED+1. in_ready is high again after ED+1.
- Throughput: one comparison per D+2 cycles with in_valid held high. For WIDTH=8 that is one accept every 6 cycles.
- Handshake rules:
  - a and b are sampled only on the handshake edge. They may change freely afterwards.
  - in_valid while busy is ignored. Nothing is sampled, the request is not queued, and the upstream must hold in_valid until it sees in_ready.
  - in_ready is a pure function of state. It does not depend combinationally on in_valid.
- Reset mid-operation (RUN or DONE): the block returns immediately to IDLE with all outputs at their reset values. No done pulse is issued for the aborted comparison.
- WIDTH=2: D=1, so the block spends a single cycle in RUN.

## Structure

- Shared package mini_alu_pkg holds:
  - FSM state encodings: ST_IDLE, ST_RUN, ST_DONE (2-bit).
  - DIGIT_W=2.
  - The counter width function clog2(WIDTH/2), minimum 1.
- One sub-module: digit_cmp2. It is a combinational 2-bit compare slice with inputs x[1:0] and y[1:0], and outputs gt and eq.
- Everything else (FSM, shift registers, counter, result registers) lives in serial_mag_compare.

## Test plan

- WIDTH=8, a=0xB4, b=0xB3 -> after reset, handshake at E0; done pulses one cycle in the cycle after E4 with a_gt_b=1, a_eq_b=0, a_lt_b=0.
- a=0x5A, b=0x5A -> a_eq_b=1 only, same 4-cycle latency.
- a=0x40, b=0xFF (differ in the MSB digit) -> a_lt_b=1; done is still at E4, not earlier. The next compare, a=0xFF, b=0x40, flips the result to a_gt_b=1.
- Hold in_valid=1 continuously, changing a/b every cycle -> accepts only every 6 cycles; each result matches the operands present at its own handshake edge; in_ready is never high while busy=1.
- Assert reset_n=0 for one cycle during RUN (after E2) -> outputs return to their reset values asynchronously; no done pulse; in_ready=1 after release; the next comparison completes normally.
- WIDTH=2 build, exhaustive sweep of all 16 a/b pairs -> each done arrives one edge after the RUN edge, and each verdict matches the unsigned compare.
